// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the digit-serial subtractor.
// Slice count and counter width derive from the module's own WIDTH/DIGIT.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DIGIT      = 4;
    localparam int DEF_NUM_SLICES = DEF_WIDTH / DEF_DIGIT;

    function automatic int cnt_width(input int num_slices);
        // Keep at least one bit so a single-slice build still has a legal counter.
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_rca.sv
// Plain ripple-carry adder; the subtractor uses one DIGIT-wide instance per slice.
// Overflow is the usual carry-into-MSB xor carry-out test.
module rippleCarryAdder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout     = w_c[WIDTH];
    assign o_overflow = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - bin: adds a + ~b + ~bin one DIGIT slice per cycle, LSB first.
// Results land in dedicated output registers only on the last slice.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int NUM_SLICES = WIDTH / DIGIT;
    localparam int CNT_W      = cnt_width(NUM_SLICES);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_subtractor: WIDTH must be divisible by DIGIT");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_nb;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_bout;
    logic               r_ovf;
    logic               r_a_msb;
    logic               r_b_msb;

    logic [DIGIT-1:0]   w_sum;
    logic               w_cout;
    logic               w_unused_ovf;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    rippleCarryAdder #(
        .WIDTH (DIGIT)
    ) u_slice_add (
        .i_a        (r_a[DIGIT-1:0]),
        .i_b        (r_nb[DIGIT-1:0]),
        .i_cin      (r_carry),
        .o_sum      (w_sum),
        .o_cout     (w_cout),
        .o_overflow (w_unused_ovf)
    );

    if (NUM_SLICES > 1) begin : g_acc_shift
        assign w_acc_next = {w_sum, r_acc[WIDTH-1:DIGIT]};
    end else begin : g_acc_whole
        assign w_acc_next = w_sum;
    end

    assign w_last = (r_cnt == CNT_W'(NUM_SLICES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = BUSY;
            BUSY:    if (w_last)   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_nb    <= '0;
            r_acc   <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_carry <= ~bin;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                    end
                end
                BUSY: begin
                    r_a     <= r_a >> DIGIT;
                    r_nb    <= r_nb >> DIGIT;
                    r_carry <= w_cout;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff <= w_acc_next;
                        r_bout <= ~w_cout;
                        r_ovf  <= (r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed vectors, handshake and reset cases.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(32), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: accept, poke in_valid during BUSY, hold out_ready low, then drain.
    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vbin, input int hold,
                          input logic [31:0] ed, input logic eb, input logic eo);
        int n;
        chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h0BADF00D; bin = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            if (n == 2) in_valid = 1'b1;
            if (n == 3) in_valid = 1'b0;
            if (n == 1) chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            step();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " diff"}, diff, ed);
        chk({tag, " bout"}, 32'(bout), 32'(eb));
        chk({tag, " overflow"}, 32'(overflow), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            chk({tag, " hold diff"}, diff, ed);
            chk({tag, " hold flags"}, {30'd0, bout, overflow}, {30'd0, eb, eo});
            chk({tag, " hold valid/ready"}, {30'd0, out_valid, in_ready}, 32'b10);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " drain valid/ready"}, {30'd0, out_valid, in_ready}, 32'b01);
        chk({tag, " drain diff kept"}, diff, ed);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        step();
        step();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset diff", diff, 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("stray out_ready", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        run_op("basic",    32'h0000000A, 32'h00000003, 1'b0, 0, 32'h00000007, 1'b0, 1'b0);
        run_op("wrap",     32'h00000000, 32'h00000001, 1'b0, 0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("sovf_neg", 32'h80000000, 32'h00000001, 1'b0, 0, 32'h7FFFFFFF, 1'b0, 1'b1);
        run_op("bin",      32'h00000005, 32'h00000005, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("sovf_pos", 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 32'h80000000, 1'b1, 1'b1);
        run_op("allones",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op("backpress", 32'h12345678, 32'h11111111, 1'b0, 5, 32'h01234567, 1'b0, 1'b0);

        // Abandon an operation partway through BUSY.
        a = 32'hFFFFFFFF; b = 32'h00000001; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst diff", diff, 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst flags", {30'd0, bout, overflow}, 32'd0);

        run_op("after_rst", 32'd100, 32'd58, 1'b0, 0, 32'd42, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
